// File: rtl/pool_reduce_unit.sv
// Windowed reduction unit: sums, maxes or averages WIN unsigned elements per window,
// or passes each element straight through in bypass mode, behind a one-deep output register.
module pool_reduce_unit #(
    parameter int DW  = 12,
    parameter int WIN = 9,
    parameter int OW  = 30
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   ops,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW-1:0]                in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OW-1:0]                sum,
    output logic [$clog2(WIN+1)-1:0]     win_cnt
);

    localparam int CW = $clog2(WIN+1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIN - 1);
    localparam logic [OW-1:0] WIN_DIV  = OW'(WIN);

    typedef enum logic [1:0] {
        MODE_SUM    = 2'b00,
        MODE_MAX    = 2'b01,
        MODE_AVG    = 2'b10,
        MODE_BYPASS = 2'b11
    } mode_t;

    // The HOLD condition lives in out_valid so a pending result can overlap the next window.
    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t          state, stateNext;
    mode_t           modeReg, modeNext, effMode;
    logic [OW-1:0]   accReg, accNext, accCandidate, result, sumNext, inExt;
    logic [DW-1:0]   maxReg, maxNext, maxCandidate;
    logic [CW-1:0]   cntNext;
    logic            validNext, accept, firstElem, windowDone, produce;

    assign in_ready = (!out_valid || out_ready) && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            modeReg   <= MODE_SUM;
            accReg    <= '0;
            maxReg    <= '0;
            win_cnt   <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= stateNext;
            modeReg   <= modeNext;
            accReg    <= accNext;
            maxReg    <= maxNext;
            win_cnt   <= cntNext;
            sum       <= sumNext;
            out_valid <= validNext;
        end
    end

    always_comb begin
        accept       = in_valid && in_ready;
        firstElem    = (state == IDLE);
        effMode      = firstElem ? mode_t'(ops) : modeReg;
        inExt        = OW'(in_data);
        accCandidate = firstElem ? inExt : accReg + inExt;
        maxCandidate = (firstElem || in_data > maxReg) ? in_data : maxReg;
        windowDone   = (effMode != MODE_BYPASS) && !firstElem && (win_cnt == LAST_CNT);
        produce      = accept && ((effMode == MODE_BYPASS) || windowDone);

        case (effMode)
            MODE_SUM: result = accCandidate;
            MODE_MAX: result = OW'(maxCandidate);
            MODE_AVG: result = accCandidate / WIN_DIV;
            default:  result = inExt;
        endcase

        stateNext = state;
        modeNext  = modeReg;
        accNext   = accReg;
        maxNext   = maxReg;
        cntNext   = win_cnt;
        sumNext   = sum;
        validNext = out_valid && !out_ready;

        if (flush) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else if (accept) begin
            modeNext = effMode;
            accNext  = accCandidate;
            maxNext  = maxCandidate;
            if (effMode == MODE_BYPASS || windowDone) begin
                stateNext = IDLE;
                cntNext   = '0;
            end else begin
                stateNext = ACC;
                cntNext   = firstElem ? CW'(1) : win_cnt + CW'(1);
            end
        end

        if (produce) begin
            sumNext   = result;
            validNext = 1'b1;
        end
    end

endmodule

// File: tb/tb_pool_reduce_unit.sv
// Self-checking bench for pool_reduce_unit: directed scenarios plus randomized traffic
// compared against a window/queue reference model.
module tb_pool_reduce_unit;

    localparam int DW  = 12;
    localparam int WIN = 9;
    localparam int OW  = 30;
    localparam int CW  = $clog2(WIN+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    ops = 2'b00;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] sum;
    logic [CW-1:0] win_cnt;

    int checks   = 0;
    int failures = 0;
    bit randReady = 1'b0;

    logic [OW-1:0] expQ[$];
    logic [DW-1:0] winQ[$];
    logic [1:0]    winMode = 2'b00;

    pool_reduce_unit #(.DW(DW), .WIN(WIN), .OW(OW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ops       (ops),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .win_cnt   (win_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: gather a window's elements, then reduce them with plain arithmetic.
    function automatic void modelFeed(input logic [DW-1:0] d, input logic [1:0] o);
        longint total;
        logic [DW-1:0] best;
        if (winQ.size() == 0) winMode = o;
        if (winMode == 2'b11) begin
            expQ.push_back(OW'(d));
            return;
        end
        winQ.push_back(d);
        if (winQ.size() == WIN) begin
            total = 0;
            best  = '0;
            foreach (winQ[i]) begin
                total += longint'(winQ[i]);
                if (winQ[i] > best) best = winQ[i];
            end
            case (winMode)
                2'b00:   expQ.push_back(OW'(total));
                2'b01:   expQ.push_back(OW'(best));
                default: expQ.push_back(OW'(total / WIN));
            endcase
            winQ.delete();
        end
    endfunction

    task automatic toNeg();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic [1:0] o);
        int budget = 0;
        in_valid = 1'b1;
        in_data  = d;
        ops      = o;
        if (randReady) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        while (!in_ready && budget < 200) begin
            toNeg();
            if (randReady) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            budget++;
        end
        checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        modelFeed(d, o);
        toNeg();
        in_valid = 1'b0;
    endtask

    task automatic doFlush();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'($urandom_range(0, 4095));
        #1;
        checkOutput("flush_blocks_input", 32'(in_ready), 32'd0);
        @(posedge clk);
        winQ.delete();
        toNeg();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_win_cnt", 32'(win_cnt), 32'd0);
    endtask

    // Every handshake on the output must deliver the oldest outstanding model result.
    always begin
        @(negedge clk);
        #3;
        if (out_valid && out_ready && reset) begin
            checkOutput("result_pending", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) checkOutput("result_value", 32'(sum), 32'(expQ.pop_front()));
        end
    end

    initial begin
        logic [DW-1:0] maxSet[9];
        int drainBudget;
        maxSet = '{12'd3, 12'd4095, 12'd7, 12'd0, 12'd12, 12'd4094, 12'd1, 12'd2, 12'd5};

        #1 reset = 1'b0;
        #2;
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_win_cnt", 32'(win_cnt), 32'd0);
        repeat (2) toNeg();
        reset = 1'b1;
        #1;
        checkOutput("post_reset_ready", 32'(in_ready), 32'd1);
        toNeg();

        for (int i = 1; i <= 9; i++) applyStimulus(DW'(i), 2'b00);
        checkOutput("sum_1to9", 32'(sum), 32'd45);
        checkOutput("sum_latency_valid", 32'(out_valid), 32'd1);
        toNeg();
        checkOutput("sum_single_cycle", 32'(out_valid), 32'd0);

        for (int i = 0; i < 9; i++) applyStimulus(maxSet[i], 2'b01);
        checkOutput("max_result", 32'(sum), 32'd4095);
        toNeg();
        for (int i = 0; i < 9; i++) applyStimulus(maxSet[i], (i == 0) ? 2'b10 : 2'b00);
        checkOutput("avg_result", 32'(sum), 32'd913);
        toNeg();

        for (int i = 0; i < 9; i++) applyStimulus(12'd4095, 2'b00);
        checkOutput("sum_no_overflow", 32'(sum), 32'd36855);
        toNeg();

        out_ready = 1'b0;
        applyStimulus(12'd10, 2'b11);
        checkOutput("bypass_first", 32'(sum), 32'd10);
        checkOutput("bypass_win_cnt", 32'(win_cnt), 32'd0);
        in_valid = 1'b1;
        in_data  = 12'd20;
        ops      = 2'b11;
        #1;
        checkOutput("bypass_stall_ready", 32'(in_ready), 32'd0);
        repeat (3) begin
            toNeg();
            checkOutput("bypass_hold_sum", 32'(sum), 32'd10);
            checkOutput("bypass_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bypass_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        modelFeed(12'd20, 2'b11);
        toNeg();
        checkOutput("bypass_second", 32'(sum), 32'd20);
        in_data = 12'd30;
        @(posedge clk);
        modelFeed(12'd30, 2'b11);
        toNeg();
        in_valid = 1'b0;
        checkOutput("bypass_third", 32'(sum), 32'd30);
        toNeg();
        checkOutput("bypass_drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 4; i++) applyStimulus(12'd7, 2'b00);
        checkOutput("partial_win_cnt", 32'(win_cnt), 32'd4);
        doFlush();
        for (int i = 0; i < 9; i++) applyStimulus(12'd1, 2'b00);
        checkOutput("after_flush_sum", 32'(sum), 32'd9);
        toNeg();
        checkOutput("after_flush_single", 32'(expQ.size()), 32'd0);

        for (int i = 0; i < 5; i++) applyStimulus(12'd100, 2'b00);
        checkOutput("pre_reset_win_cnt", 32'(win_cnt), 32'd5);
        reset = 1'b0;
        #1;
        checkOutput("midreset_sum", 32'(sum), 32'd0);
        checkOutput("midreset_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_win_cnt", 32'(win_cnt), 32'd0);
        winQ.delete();
        expQ.delete();
        toNeg();
        reset = 1'b1;
        toNeg();
        for (int i = 0; i < 9; i++) applyStimulus(12'd2, 2'b00);
        checkOutput("after_reset_sum", 32'(sum), 32'd18);
        toNeg();

        randReady = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 24) == 0) doFlush();
            else applyStimulus(DW'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)));
            checkOutput("rand_win_cnt", 32'(win_cnt), 32'(winQ.size()));
        end

        randReady   = 1'b0;
        out_ready   = 1'b1;
        drainBudget = 0;
        while (expQ.size() > 0 && drainBudget < 50) begin
            toNeg();
            drainBudget++;
        end
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
        toNeg();
        checkOutput("final_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
